alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, registered successor to the 8-bit add/sub ALU: a WIDTH-bit ALU with eight operations, a start/done handshake, an optional multi-cycle shift-add multiplier, and four status flags. The block sits between the A/B registers and the shared data bus. Its result register drives the bus through a tri-state buffer under `enable_output`.

## Interface

- `WIDTH`, default 8, is the operand, result and bus width. It must be at least 2.
- `clk`: input, 1 bit, the single system clock. All state updates on its rising edge.
- `rst_n`: input, 1 bit, asynchronous active-low reset.
- `start`: input, 1 bit, requests an operation. It is sampled only when `busy`=0.
- `op`: input, 3 bits, selects the operation:
  - 000 ADD, 001 SUB, 010 AND, 011 OR
  - 100 XOR, 101 SHL1, 110 SHR1 (logical), 111 MUL
- `reg_a`: input, WIDTH bits, operand A.
- `reg_b`: input, WIDTH bits, operand B.
- `enable_output`: input, 1 bit. When 1, the result register is driven onto `bus`.
- `bus`: output, WIDTH bits. It carries the result register when `enable_output`=1 and is all-Z otherwise.
- `busy`: output, 1 bit, high while a multiply is in progress.
- `done`: output, 1 bit, a one-cycle pulse when the result and flags have been updated.
- `CF`: output, 1 bit, registered carry flag.
- `ZF`: output, 1 bit, registered zero flag.
- `NF`: output, 1 bit, registered negative flag.
- `VF`: output, 1 bit, registered overflow flag.

## Operation

**Reset** is asynchronous and active-low. While `rst_n`=0:
- The state is IDLE.
- The result register, CF, ZF, NF, VF, `busy` and `done` are all 0.
- The multiply counter and partial product are cleared.
- Asserting reset during a multiply aborts it; no `done` is produced.

**States**
- IDLE: `start`=1 with `op`≠111 performs a single-cycle op and stays in IDLE. `start`=1 with `op`=111 goes to MUL.
- MUL: runs WIDTH iterations, then returns to IDLE.

**Single-cycle ops** use `reg_a` and `reg_b` as sampled on the accept edge.
- ADD: result = A+B. CF = carry out. VF = signed overflow.
- SUB: computed as A+~B+1. CF = carry out (1 means no borrow). VF = signed overflow.
- AND, OR, XOR: CF=0, VF=0.
- SHL1: result = A<<1. CF = A[WIDTH-1]. VF=0.
- SHR1: result = A>>1, zero-filled. CF = A[0]. VF=0.

**MUL** is an unsigned shift-and-add multiply.
- Operands are latched on the accept edge; later changes on `reg_a`/`reg_b` are ignored.
- One partial-product iteration runs per cycle.
- Result = low WIDTH bits of the 2·WIDTH product.
- CF = VF = 1 if the upper WIDTH bits are non-zero.

**Flag rules**
- On every completion: ZF = (result==0), NF = result[WIDTH-1].
- Flags and result change only on completion; they hold otherwise.

**Bus** is a pure function of `enable_output` and the result register, independent of `busy`. During a multiply the bus shows the previous result.

## Timing

- Single-cycle op accepted at edge k:
  - Result and flags are updated at edge k.
  - `done`=1 for the cycle following edge k.
  - `busy` stays 0.
- MUL accepted at edge k:
  - `busy`=1 from edge k.
  - Iterations occur at edges k+1 through k+WIDTH.
  - Result and flags are written at edge k+WIDTH, and `busy` falls at that same edge.
  - `done`=1 for the cycle following edge k+WIDTH.
- `start` while `busy`=1 is ignored; it is neither queued nor an error.
- Back-to-back operation: `start` is accepted in the same cycle that `done` is high. A single-cycle op can therefore be accepted every cycle, giving `done` high on consecutive cycles.
- `op` values outside the enumerated set cannot occur (3-bit, fully decoded).

## Configuration

- `ALU_SEQ_MUL_EN` defined:
  - The MUL state, iteration counter, partial-product register and the op 111 path are compiled in, as described above.
- `ALU_SEQ_MUL_EN` undefined:
  - No multiplier hardware is present.
  - op 111 is a single-cycle NOP: result and all flags are unchanged, `done` pulses in the cycle after the accept edge, and `busy` never asserts.

## Test plan

All scenarios use WIDTH=8.

- **ADD overflow:** ADD A=0x7F, B=0x01 -> result 0x80, NF=1, VF=1, CF=0, ZF=0; `done` high exactly one cycle after the accept edge.
- **SUB zero:** SUB A=0x05, B=0x05 -> result 0x00, ZF=1, CF=1, VF=0, NF=0. Then SUB A=0x03, B=0x05 -> result 0xFE, CF=0, NF=1.
- **Shift carry-out:** SHL1 A=0x81 -> result 0x02, CF=1. SHR1 A=0x01 -> result 0x00, CF=1, ZF=1.
- **MUL:** MUL A=0x12, B=0x0F, with macro defined -> `busy` high for 8 cycles. A second `start` pulsed mid-way is ignored. `reg_a` changed after accept has no effect. Result 0x0E, CF=VF=1, a single `done` pulse.
- **Bus and reset:**
  - `enable_output`=0 -> `bus` all Z; toggling to 1 shows the last result in the same cycle.
  - Assert `rst_n`=0 three cycles into a MUL -> `busy`, `done`, result and flags are 0 immediately; no `done` follows release.
- **Macro undefined:** op 111 with result 0x80 held from a prior ADD -> `done` one cycle later, result 0x80 and flags unchanged, `busy` never 1.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with start/done handshake, CF/ZF/NF/VF flags and tri-state bus output.
// Define ALU_SEQ_MUL_EN to build the multi-cycle shift-add multiplier for op 111; otherwise op 111 is a NOP.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] reg_a,
  input  logic [WIDTH-1:0] reg_b,
  input  logic             enable_output,
  output logic [WIDTH-1:0] bus,
  output logic             busy,
  output logic             done,
  output logic             CF,
  output logic             ZF,
  output logic             NF,
  output logic             VF
);
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  logic [WIDTH-1:0] r_result;
  logic             r_cf, r_zf, r_nf, r_vf, r_done;
  logic             w_sub, w_cf, w_vf;
  logic [WIDTH-1:0] w_b_op, w_res;
  logic [WIDTH:0]   w_sum;
  logic             w_wr, w_done_nx, w_wr_cf, w_wr_vf;
  logic [WIDTH-1:0] w_wr_res;

  // SUB shares the adder as A + ~B + 1, so CF=1 means no borrow
  always_comb begin
    w_sub  = op == OP_SUB;
    w_b_op = w_sub ? ~reg_b : reg_b;
    w_sum  = {1'b0, reg_a} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_sub};
    w_res  = '0;
    w_cf   = 1'b0;
    w_vf   = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        w_res = w_sum[WIDTH-1:0];
        w_cf  = w_sum[WIDTH];
        w_vf  = (reg_a[WIDTH-1] == w_b_op[WIDTH-1]) && (w_sum[WIDTH-1] != reg_a[WIDTH-1]);
      end
      OP_AND: w_res = reg_a & reg_b;
      OP_OR:  w_res = reg_a | reg_b;
      OP_XOR: w_res = reg_a ^ reg_b;
      OP_SHL: begin
        w_res = {reg_a[WIDTH-2:0], 1'b0};
        w_cf  = reg_a[WIDTH-1];
      end
      OP_SHR: begin
        w_res = {1'b0, reg_a[WIDTH-1:1]};
        w_cf  = reg_a[0];
      end
      default: ;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic {S_IDLE, S_MUL} state_t;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  state_t             r_state, w_state_nx;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc, r_mcand, w_acc_nx;
  logic [WIDTH-1:0]   r_mplier;
  logic               w_mul_last, w_single;

  always_comb begin
    w_acc_nx   = r_acc + (r_mplier[0] ? r_mcand : '0);
    w_mul_last = (r_state == S_MUL) && (r_cnt == CW'(WIDTH - 1));
    w_state_nx = r_state;
    if (r_state == S_IDLE && start && op == OP_MUL)
      w_state_nx = S_MUL;
    else if (w_mul_last)
      w_state_nx = S_IDLE;
  end

  // operands are captured on every idle edge, so the accept edge freezes them
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else begin
      r_state <= w_state_nx;
      if (r_state == S_IDLE) begin
        r_cnt    <= '0;
        r_acc    <= '0;
        r_mcand  <= {{WIDTH{1'b0}}, reg_a};
        r_mplier <= reg_b;
      end else begin
        r_cnt    <= r_cnt + 1'b1;
        r_acc    <= w_acc_nx;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
      end
    end

  assign busy      = r_state == S_MUL;
  assign w_single  = start && !busy && op != OP_MUL;
  assign w_wr      = w_single || w_mul_last;
  assign w_done_nx = w_wr;
  assign w_wr_res  = w_mul_last ? w_acc_nx[WIDTH-1:0] : w_res;
  assign w_wr_cf   = w_mul_last ? |w_acc_nx[2*WIDTH-1:WIDTH] : w_cf;
  assign w_wr_vf   = w_mul_last ? |w_acc_nx[2*WIDTH-1:WIDTH] : w_vf;
`else
  assign busy      = 1'b0;
  assign w_wr      = start && op != OP_MUL;
  assign w_done_nx = start;
  assign w_wr_res  = w_res;
  assign w_wr_cf   = w_cf;
  assign w_wr_vf   = w_vf;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_result <= '0;
      r_cf     <= 1'b0;
      r_zf     <= 1'b0;
      r_nf     <= 1'b0;
      r_vf     <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_done_nx;
      if (w_wr) begin
        r_result <= w_wr_res;
        r_cf     <= w_wr_cf;
        r_zf     <= w_wr_res == '0;
        r_nf     <= w_wr_res[WIDTH-1];
        r_vf     <= w_wr_vf;
      end
    end

  assign bus  = enable_output ? r_result : {WIDTH{1'bz}};
  assign done = r_done;
  assign CF   = r_cf;
  assign ZF   = r_zf;
  assign NF   = r_nf;
  assign VF   = r_vf;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table, multi-cycle corner sequences and random back-to-back ops against an integer model.
module tb_alu_seq;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, en = 1'b1;
  logic [2:0] op = '0;
  logic [7:0] a = '0, b = '0;
  wire  [7:0] bus;
  logic       busy, done, cf, zf, nf, vf;
  int         n_vec = 0, n_err = 0;
  logic [7:0] m_res = '0;
  logic       m_cf = 0, m_zf = 0, m_nf = 0, m_vf = 0;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a, b, res;
    logic       cf, zf, nf, vf;
  } vec_t;
  vec_t tbl[12];

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .reg_a(a), .reg_b(b),
    .enable_output(en), .bus(bus), .busy(busy), .done(done),
    .CF(cf), .ZF(zf), .NF(nf), .VF(vf)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_res"}, bus, m_res);
    check({tag, "_flags"}, {cf, zf, nf, vf}, {m_cf, m_zf, m_nf, m_vf});
  endtask

  // integer-arithmetic reference: result and flags from the operation's definition
  task automatic model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    int r, s;
    bit c, v, wr;
    r = 0; s = 0; c = 0; v = 0; wr = 1;
    case (o)
      3'd0: begin r = int'(x) + int'(y); s = int'($signed(x)) + int'($signed(y)); c = r > 255; v = s > 127 || s < -128; end
      3'd1: begin r = int'(x) - int'(y) + 256; s = int'($signed(x)) - int'($signed(y)); c = r > 255; v = s > 127 || s < -128; end
      3'd2: r = int'(x & y);
      3'd3: r = int'(x | y);
      3'd4: r = int'(x ^ y);
      3'd5: begin r = int'(x) * 2; c = x[7]; end
      3'd6: begin r = int'(x) / 2; c = x[0]; end
      default: begin
`ifdef ALU_SEQ_MUL_EN
        r = int'(x) * int'(y); c = r > 255; v = c;
`else
        wr = 0;
`endif
      end
    endcase
    if (wr) begin
      m_res = r[7:0];
      m_cf = c; m_vf = v; m_zf = m_res == 8'h00; m_nf = m_res[7];
    end
  endtask

  // leaves start high so the caller can issue the next op back-to-back
  task automatic apply_single(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk); start = 1; op = o; a = x; b = y;
    @(posedge clk); #1;
    model(o, x, y);
    check("single_done", done, 1);
    check("single_busy", busy, 0);
    check_model("single");
  endtask

`ifdef ALU_SEQ_MUL_EN
  task automatic mul_seq(input logic [7:0] x, input logic [7:0] y, input bit disturb);
    logic [7:0] prev;
    prev = m_res;
    @(negedge clk); start = 1; op = 3'd7; a = x; b = y;
    @(posedge clk); #1;
    check("mul_busy_k", busy, 1);
    check("mul_done_k", done, 0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      start = disturb && i == 3; op = 3'd0;
      a = disturb ? ~x : x; b = disturb ? x : y;
      @(posedge clk); #1;
      if (i < 8) begin
        check("mul_busy", busy, 1);
        check("mul_done_early", done, 0);
        check("mul_bus_prev", bus, prev);
      end else begin
        check("mul_busy_end", busy, 0);
        check("mul_done", done, 1);
      end
    end
    model(3'd7, x, y);
    check_model("mul");
    @(negedge clk); start = 0;
    @(posedge clk); #1;
    check("mul_done_once", done, 0);
  endtask
`endif

  initial begin
    int ndone;
    logic zok;
    tbl[0]  = '{3'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[1]  = '{3'd1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{3'd1, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{3'd5, 8'h81, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{3'd6, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{3'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{3'd3, 8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{3'd4, 8'hAA, 8'hAA, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{3'd1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{3'd0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{3'd5, 8'h40, 8'h00, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0};

    #2;
    check("rst_bus", bus, 8'h00);
    check("rst_busy_done", {busy, done}, 2'b00);
    check("rst_flags", {cf, zf, nf, vf}, 4'h0);
    @(negedge clk); rst_n = 1;

    foreach (tbl[i]) begin
      apply_single(tbl[i].op, tbl[i].a, tbl[i].b);
      check($sformatf("tbl%0d_res", i), bus, tbl[i].res);
      check($sformatf("tbl%0d_flags", i), {cf, zf, nf, vf}, {tbl[i].cf, tbl[i].zf, tbl[i].nf, tbl[i].vf});
      @(negedge clk); start = 0;
      @(posedge clk); #1;
      check($sformatf("tbl%0d_done_pulse", i), done, 0);
    end

    apply_single(3'd0, 8'h7F, 8'h01);
    @(negedge clk); start = 0; en = 0;
    #1;
    zok = (bus === 8'hzz) || (bus === 8'h00);
    check("bus_off_z", zok, 1);
    en = 1;
    #1;
    check("bus_on_same_cycle", bus, 8'h80);

`ifdef ALU_SEQ_MUL_EN
    mul_seq(8'h12, 8'h0F, 1);
    check("mul_const_res", bus, 8'h0E);
    check("mul_const_cv", {cf, vf}, 2'b11);
`else
    apply_single(3'd7, 8'h12, 8'h0F);
    check("nop_res", bus, 8'h80);
    check("nop_flags", {cf, zf, nf, vf}, 4'b0011);
    @(negedge clk); start = 0;
    @(posedge clk); #1;
    check("nop_done_pulse", done, 0);
    check("nop_busy", busy, 0);
`endif

    for (int i = 0; i < 150; i++) begin
      logic [2:0] o;
      logic [7:0] x, y;
      o = 3'($urandom_range(0, 7)); x = 8'($urandom); y = 8'($urandom);
`ifdef ALU_SEQ_MUL_EN
      if (o == 3'd7) mul_seq(x, y, 0);
      else apply_single(o, x, y);
`else
      apply_single(o, x, y);
`endif
    end
    @(negedge clk); start = 0;

`ifdef ALU_SEQ_MUL_EN
    @(negedge clk); start = 1; op = 3'd7; a = 8'h12; b = 8'h0F;
    @(posedge clk);
    @(negedge clk); start = 0;
    repeat (3) @(posedge clk);
`else
    apply_single(3'd0, 8'h7F, 8'h01);
    @(negedge clk); start = 0;
    @(posedge clk);
`endif
    #2; rst_n = 0;
    #1;
    check("arst_busy_done", {busy, done}, 2'b00);
    check("arst_res", bus, 8'h00);
    check("arst_flags", {cf, zf, nf, vf}, 4'h0);
    m_res = '0; m_cf = 0; m_zf = 0; m_nf = 0; m_vf = 0;
    @(negedge clk); rst_n = 1;
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("arst_no_done", ndone, 0);
    check("arst_idle_busy", busy, 0);
    check_model("arst_hold");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
